result_checker: RTL and testbench

RESULT_CHECKER -- requirements
Module: result_checker

---
 rtl/checker_pkg.sv | 19 +
 rtl/checkpoint_table.sv | 49 ++++
 rtl/result_checker.sv | 138 +++++++++++++
 tb/tb_result_checker.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/checker_pkg.sv
// rtl/checker_pkg.sv - shared types and constants for the result checker
package checker_pkg;

   localparam int          WORD_W           = 64;
   localparam logic [15:0] WD_LIMIT_DEFAULT = 16'hFF;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RUN     = 3'd1,
      ST_SETTLE  = 3'd2,
      ST_DONE    = 3'd3,
      ST_TIMEOUT = 3'd4
   } state_t;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/checkpoint_table.sv
// rtl/checkpoint_table.sv - (pc, expected data) checkpoint registers
// Sync write, async read; out-of-range indices write nothing and read zero.
module checkpoint_table
   import checker_pkg::*;
#(
   parameter int NUM_CHECKS = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [1:0]        wr_idx,
   input  logic [WORD_W-1:0] wr_pc,
   input  logic [WORD_W-1:0] wr_exp,
   input  logic [1:0]        rd_idx,
   output logic [WORD_W-1:0] rd_pc,
   output logic [WORD_W-1:0] rd_exp
);

   logic [WORD_W-1:0] pc_q  [NUM_CHECKS];
   logic [WORD_W-1:0] exp_q [NUM_CHECKS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int e = 0; e < NUM_CHECKS; e++) begin
            pc_q[e]  <= '0;
            exp_q[e] <= '0;
         end
      end else if (wr_en) begin
         for (int e = 0; e < NUM_CHECKS; e++) begin
            if (wr_idx == 2'(e)) begin
               pc_q[e]  <= wr_pc;
               exp_q[e] <= wr_exp;
            end
         end
      end
   end

   always_comb begin
      rd_pc  = '0;
      rd_exp = '0;
      for (int e = 0; e < NUM_CHECKS; e++) begin
         if (rd_idx == 2'(e)) begin
            rd_pc  = pc_q[e];
            rd_exp = exp_q[e];
         end
      end
   end

endmodule

// File: rtl/result_checker.sv
// rtl/result_checker.sv - watches PC/data-memory traffic and scores checkpoints
// A checkpoint triggers once currentpc reaches its pc; dmemout is sampled one cycle later.
module result_checker
   import checker_pkg::*;
#(
   parameter int          NUM_CHECKS = 2,
   parameter logic [15:0] WD_LIMIT   = WD_LIMIT_DEFAULT
) (
   input  logic              CLK,
   input  logic              resetl,
   input  logic [WORD_W-1:0] currentpc,
   input  logic [WORD_W-1:0] dmemout,
   input  logic              cfg_we,
   input  logic [1:0]        cfg_idx,
   input  logic [WORD_W-1:0] cfg_pc,
   input  logic [WORD_W-1:0] cfg_expect,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              timeout,
   output logic              all_passed,
   output logic [7:0]        pass_cnt,
   output logic [7:0]        fail_cnt,
   output logic [WORD_W-1:0] fail_data
);

   state_t            state;
   logic [1:0]        idx;
   logic [15:0]       wd;
   logic [WORD_W-1:0] entry_pc;
   logic [WORD_W-1:0] entry_exp;
   logic              idle_like;
   logic              wd_expired;
   logic              hit;
   logic              last_entry;
   logic [15:0]       wd_inc;
   logic [7:0]        pass_nxt;
   logic [7:0]        fail_nxt;

   assign idle_like = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_TIMEOUT);

   checkpoint_table #(.NUM_CHECKS(NUM_CHECKS)) u_table (
      .clk    (CLK),
      .rst_n  (resetl),
      .wr_en  (cfg_we && idle_like),
      .wr_idx (cfg_idx),
      .wr_pc  (cfg_pc),
      .wr_exp (cfg_expect),
      .rd_idx (idx),
      .rd_pc  (entry_pc),
      .rd_exp (entry_exp)
   );

   always_comb begin
      wd_inc     = wd + 16'd1;
      wd_expired = (wd_inc == WD_LIMIT);
      hit        = (dmemout == entry_exp);
      last_entry = (idx == 2'(NUM_CHECKS - 1));
      pass_nxt   = hit ? sat_inc8(pass_cnt) : pass_cnt;
      fail_nxt   = hit ? fail_cnt : sat_inc8(fail_cnt);
   end

   always_ff @(posedge CLK or negedge resetl) begin
      if (!resetl) begin
         state      <= ST_IDLE;
         idx        <= '0;
         wd         <= '0;
         pass_cnt   <= '0;
         fail_cnt   <= '0;
         fail_data  <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         timeout    <= 1'b0;
         all_passed <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE, ST_TIMEOUT: begin
               if (start) begin
                  state      <= ST_RUN;
                  idx        <= '0;
                  wd         <= '0;
                  pass_cnt   <= '0;
                  fail_cnt   <= '0;
                  fail_data  <= '0;
                  busy       <= 1'b1;
                  done       <= 1'b0;
                  timeout    <= 1'b0;
                  all_passed <= 1'b0;
               end
            end
            ST_RUN: begin
               wd <= wd_inc;
               if (wd_expired) begin
                  state   <= ST_TIMEOUT;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  timeout <= 1'b1;
               end else if (currentpc >= entry_pc) begin
                  state <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               wd <= wd_inc;
               // The watchdog wins: a compare landing on the expiry edge is dropped.
               if (wd_expired) begin
                  state   <= ST_TIMEOUT;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  timeout <= 1'b1;
               end else begin
                  pass_cnt <= pass_nxt;
                  fail_cnt <= fail_nxt;
                  if (!hit && fail_cnt == 8'd0) begin
                     fail_data <= dmemout;
                  end
                  if (last_entry) begin
                     state      <= ST_DONE;
                     busy       <= 1'b0;
                     done       <= 1'b1;
                     all_passed <= (pass_nxt == 8'(NUM_CHECKS));
                  end else begin
                     idx   <= idx + 2'd1;
                     state <= ST_RUN;
                  end
               end
            end
            default: begin
               state      <= ST_IDLE;
               busy       <= 1'b0;
               done       <= 1'b0;
               timeout    <= 1'b0;
               all_passed <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_result_checker.sv
// tb/tb_result_checker.sv - directed scoreboard bench for result_checker
module tb_result_checker;

   logic        CLK = 1'b0;
   logic        resetl;
   logic [63:0] currentpc;
   logic [63:0] dmemout;
   logic        cfg_we;
   logic [1:0]  cfg_idx;
   logic [63:0] cfg_pc;
   logic [63:0] cfg_expect;
   logic        start;
   logic        busy;
   logic        done;
   logic        timeout;
   logic        all_passed;
   logic [7:0]  pass_cnt;
   logic [7:0]  fail_cnt;
   logic [63:0] fail_data;

   typedef struct {
      logic [7:0]  p;
      logic [7:0]  f;
      logic [63:0] fd;
      logic        to;
      logic        ap;
   } res_t;

   res_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   n;

   always #5 CLK = ~CLK;

   result_checker dut (
      .CLK        (CLK),
      .resetl     (resetl),
      .currentpc  (currentpc),
      .dmemout    (dmemout),
      .cfg_we     (cfg_we),
      .cfg_idx    (cfg_idx),
      .cfg_pc     (cfg_pc),
      .cfg_expect (cfg_expect),
      .start      (start),
      .busy       (busy),
      .done       (done),
      .timeout    (timeout),
      .all_passed (all_passed),
      .pass_cnt   (pass_cnt),
      .fail_cnt   (fail_cnt),
      .fail_data  (fail_data)
   );

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cfg(input logic [1:0] i, input logic [63:0] p, input logic [63:0] e);
      cfg_we = 1'b1; cfg_idx = i; cfg_pc = p; cfg_expect = e;
      tick();
      cfg_we = 1'b0;
   endtask

   task automatic push(input logic [7:0] p, input logic [7:0] f, input logic [63:0] fd,
                       input logic to, input logic ap);
      res_t r;
      r.p = p; r.f = f; r.fd = fd; r.to = to; r.ap = ap;
      sb.push_back(r);
   endtask

   task automatic score(input string tag);
      res_t r;
      chk({tag, "_sb_depth"}, 64'(sb.size()), 64'd1);
      if (sb.size() > 0) begin
         r = sb.pop_front();
         chk({tag, "_done"}, done, 1'b1);
         chk({tag, "_pass"}, pass_cnt, r.p);
         chk({tag, "_fail"}, fail_cnt, r.f);
         chk({tag, "_fdata"}, fail_data, r.fd);
         chk({tag, "_timeout"}, timeout, r.to);
         chk({tag, "_allp"}, all_passed, r.ap);
      end
   endtask

   // PC ramps by 4 per cycle; dmemout is correct only in the cycle after each trigger.
   task automatic ramp_run(input logic [63:0] d34, input logic [63:0] d58, input bit inject,
                           output int cyc);
      currentpc = '0; dmemout = '0; start = 1'b1;
      tick();
      start = 1'b0;
      cyc = 0;
      while (!done && cyc < 64) begin
         currentpc = 64'(4 * cyc);
         dmemout = (currentpc == 64'h34) ? d34 : (currentpc == 64'h58) ? d58 : 64'hDEAD;
         if (inject && currentpc == 64'h40) begin
            cfg_we = 1'b1; cfg_idx = 2'd1; cfg_pc = '0; cfg_expect = 64'hBAD; start = 1'b1;
         end
         tick();
         cfg_we = 1'b0; start = 1'b0;
         cyc++;
      end
   endtask

   // Fixed PC; dmemout valid only in run cycles 2 and 4.
   task automatic run_seq(input logic [63:0] pc, input logic [63:0] d2, input logic [63:0] d4,
                          input int budget, output int cyc);
      currentpc = pc; dmemout = '0; start = 1'b1;
      tick();
      start = 1'b0;
      cyc = 0;
      while (!done && cyc < budget) begin
         dmemout = (cyc == 1) ? d2 : (cyc == 3) ? d4 : 64'hDEAD;
         tick();
         cyc++;
      end
   endtask

   initial begin
      #50000;
      $display("FAIL global_time_limit observed=expired expected=finish");
      $fatal(1, "time limit");
   end

   initial begin
      resetl = 1'b0; currentpc = '0; dmemout = '0; cfg_we = 1'b0; cfg_idx = '0;
      cfg_pc = '0; cfg_expect = '0; start = 1'b0;
      tick(); tick();
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_pass", pass_cnt, 8'd0);
      chk("rst_fdata", fail_data, 64'd0);
      resetl = 1'b1;
      tick();

      cfg(2'd0, 64'h30, 64'hF);
      cfg(2'd1, 64'h54, 64'h123456789ABCDEF0);
      push(8'd2, 8'd0, 64'd0, 1'b0, 1'b1);
      ramp_run(64'hF, 64'h123456789ABCDEF0, 1'b0, n);
      score("pass2");
      chk("pass2_cycles", 64'(n), 64'd23);
      tick(); tick(); tick();
      chk("hold_done", done, 1'b1);
      chk("hold_pass", pass_cnt, 8'd2);

      push(8'd1, 8'd1, 64'hE, 1'b0, 1'b0);
      ramp_run(64'hE, 64'h123456789ABCDEF0, 1'b0, n);
      score("mismatch");

      push(8'd2, 8'd0, 64'd0, 1'b0, 1'b1);
      ramp_run(64'hF, 64'h123456789ABCDEF0, 1'b1, n);
      score("busy_ignore");
      push(8'd2, 8'd0, 64'd0, 1'b0, 1'b1);
      ramp_run(64'hF, 64'h123456789ABCDEF0, 1'b0, n);
      score("table_kept");

      push(8'd0, 8'd0, 64'd0, 1'b1, 1'b0);
      run_seq(64'h10, 64'd0, 64'd0, 300, n);
      score("wdog");
      chk("wdog_cycles", 64'(n), 64'd255);
      chk("wdog_busy", busy, 1'b0);

      // Reset lands mid-cycle while the second entry is settling.
      currentpc = '0; start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (n < 22) begin
         currentpc = 64'(4 * n);
         dmemout = (currentpc == 64'h34) ? 64'hE : 64'hDEAD;
         tick();
         n++;
      end
      currentpc = 64'h58;
      chk("pre_rst_busy", busy, 1'b1);
      chk("pre_rst_fail", fail_cnt, 8'd1);
      #2 resetl = 1'b0;
      #1;
      chk("arst_busy", busy, 1'b0);
      chk("arst_done", done, 1'b0);
      chk("arst_timeout", timeout, 1'b0);
      chk("arst_allp", all_passed, 1'b0);
      chk("arst_pass", pass_cnt, 8'd0);
      chk("arst_fail", fail_cnt, 8'd0);
      chk("arst_fdata", fail_data, 64'd0);
      tick();
      resetl = 1'b1;
      tick(); tick();
      chk("post_rst_idle", busy, 1'b0);

      push(8'd2, 8'd0, 64'd0, 1'b0, 1'b1);
      run_seq(64'h10, 64'd0, 64'd0, 20, n);
      score("empty_tbl");
      chk("empty_tbl_cycles", 64'(n), 64'd4);

      cfg(2'd0, 64'h30, 64'hA);
      cfg(2'd1, 64'h30, 64'hB);
      push(8'd2, 8'd0, 64'd0, 1'b0, 1'b1);
      run_seq(64'h40, 64'hA, 64'hB, 20, n);
      score("same_pc");
      chk("same_pc_cycles", 64'(n), 64'd4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
